// File: rtl/target_zone_tracker_if.sv
// Pixel-stream in / zone-decision out bundle for target_zone_tracker.
// master = pixel source + result consumer, slave = the tracker.
interface target_zone_tracker_if #(
    parameter int N_ZONES = 5,
    parameter int CNT_W   = 20
) ();
    localparam int ZW = $clog2(N_ZONES);

    logic             pixel_valid;
    logic             is_orange;
    logic             vsync;
    logic [ZW-1:0]    zone_idx;
    logic [1:0]       steer;
    logic             target_valid;
    logic [CNT_W-1:0] best_count;
    logic             frame_done;

    modport master (
        output pixel_valid, is_orange, vsync,
        input  zone_idx, steer, target_valid, best_count, frame_done
    );

    modport slave (
        input  pixel_valid, is_orange, vsync,
        output zone_idx, steer, target_valid, best_count, frame_done
    );
endinterface

// File: rtl/target_zone_tracker.sv
// Per-band target pixel counter with end-of-frame argmax, threshold and publish.
// Optional macro TRACKER_HYST_EN: require HYST_FRAMES agreeing frames before publishing.
module target_zone_acc #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (reset || clr)          cnt <= '0;
        else if (inc && cnt != '1) cnt <= cnt + CNT_W'(1);
    end
endmodule

module target_zone_tracker #(
    parameter int H_ACTIVE    = 640,
    parameter int N_ZONES     = 5,
    parameter int CNT_W       = 20,
    parameter int PIX_THRESH  = 2000,
    parameter int HYST_FRAMES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    target_zone_tracker_if.slave  bus
);
    localparam int ZONE_W = H_ACTIVE / N_ZONES;
    localparam int ZW     = $clog2(N_ZONES);
    localparam int COL_W  = (ZONE_W > 1) ? $clog2(ZONE_W) : 1;
    localparam logic [ZW-1:0]    LAST_ZONE = ZW'(N_ZONES - 1);
    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(ZONE_W - 1);

    typedef enum logic [1:0] {ACCUM, SCAN, DECIDE} state_t;
    state_t state_q, state_d;

    logic [COL_W-1:0]              col_in_zone;
    logic [ZW-1:0]                 zone_ctr, scan_idx, arg_max, zone_q;
    logic                          pv_q, vs_q, vs_qq, vs_fall;
    logic [CNT_W-1:0]              max_cnt, best_q;
    logic [N_ZONES-1:0][CNT_W-1:0] acc;
    logic [N_ZONES-1:0]            acc_inc, acc_clr;
    logic [ZW:0]                   cand;     // {valid, zone}
    logic [1:0]                    steer_q;
    logic                          tv_q, done_q, publish;

    // Two-flop vsync history: the fall is seen one cycle after vsync is first sampled low.
    assign vs_fall = vs_qq & ~vs_q;
    assign cand    = (32'(max_cnt) >= PIX_THRESH) ? {1'b1, arg_max} : '0;

    function automatic logic [1:0] steer_of(input logic [ZW:0] c);
        logic [ZW-1:0] z;
        z = c[ZW-1:0];
        if (!c[ZW]) return 2'b00;
        if (N_ZONES % 2 == 1) begin
            if (z == ZW'((N_ZONES - 1) / 2)) return 2'b10;
            return (z < ZW'((N_ZONES - 1) / 2)) ? 2'b01 : 2'b11;
        end
        return (z < ZW'(N_ZONES / 2)) ? 2'b01 : 2'b11;
    endfunction

    // Column/zone position within the current line.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_in_zone <= '0;
            zone_ctr    <= '0;
            pv_q        <= 1'b0;
        end else begin
            pv_q <= bus.pixel_valid;
            if (bus.pixel_valid) begin
                if (col_in_zone == LAST_COL) begin
                    col_in_zone <= '0;
                    if (zone_ctr != LAST_ZONE) zone_ctr <= zone_ctr + ZW'(1);
                end else begin
                    col_in_zone <= col_in_zone + COL_W'(1);
                end
            end else if (pv_q) begin
                col_in_zone <= '0;
                zone_ctr    <= '0;
            end
        end
    end

    for (genvar z = 0; z < N_ZONES; z++) begin : g_zone
        assign acc_inc[z] = (state_q == ACCUM) && bus.pixel_valid && bus.is_orange &&
                            (zone_ctr == ZW'(z));
        assign acc_clr[z] = (state_q == SCAN) && (scan_idx == ZW'(z));
        target_zone_acc #(.CNT_W(CNT_W)) u_acc (
            .clk   (clk),
            .reset (reset),
            .inc   (acc_inc[z]),
            .clr   (acc_clr[z]),
            .cnt   (acc[z])
        );
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (vs_fall) state_d = SCAN;
            SCAN:    if (scan_idx == LAST_ZONE) state_d = DECIDE;
            DECIDE:  state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

`ifdef TRACKER_HYST_EN
    logic [ZW:0] prev_cand;
    logic [3:0]  hyst_cnt, hyst_nxt;
    logic        same_pub;

    always_comb begin
        same_pub = (cand == {tv_q, zone_q});
        hyst_nxt = (cand == prev_cand) ? hyst_cnt + 4'd1 : 4'd1;
        publish  = !same_pub && (hyst_nxt >= 4'(HYST_FRAMES));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_cand <= '0;
            hyst_cnt  <= '0;
        end else if (state_q == DECIDE) begin
            prev_cand <= cand;
            hyst_cnt  <= (same_pub || publish) ? 4'd0 : hyst_nxt;
        end
    end
`else
    // HYST_FRAMES has no effect here; every evaluated candidate is published.
    assign publish = 1'b1 | (HYST_FRAMES == 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ACCUM;
            vs_q     <= 1'b1;
            vs_qq    <= 1'b1;
            scan_idx <= '0;
            max_cnt  <= '0;
            arg_max  <= '0;
            tv_q     <= 1'b0;
            zone_q   <= '0;
            steer_q  <= 2'b00;
            best_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vs_q    <= bus.vsync;
            vs_qq   <= vs_q;
            done_q  <= 1'b0;
            case (state_q)
                ACCUM: begin
                    scan_idx <= '0;
                    max_cnt  <= '0;
                    arg_max  <= '0;
                end
                SCAN: begin
                    // Strictly greater keeps the lowest index on ties.
                    if (acc[scan_idx] > max_cnt) begin
                        max_cnt <= acc[scan_idx];
                        arg_max <= scan_idx;
                    end
                    scan_idx <= scan_idx + ZW'(1);
                end
                DECIDE: begin
                    best_q <= max_cnt;
                    done_q <= 1'b1;
                    if (publish) begin
                        tv_q    <= cand[ZW];
                        zone_q  <= cand[ZW-1:0];
                        steer_q <= steer_of(cand);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.zone_idx     = zone_q;
    assign bus.steer        = steer_q;
    assign bus.target_valid = tv_q;
    assign bus.best_count   = best_q;
    assign bus.frame_done   = done_q;
endmodule

// File: doc/target_zone_tracker.md
Name: target_zone_tracker

Overview:
- Parametrised successor to the single-flag orange classifier. Splits each active line into N_ZONES equal vertical bands and counts target (is_orange) pixels per band over a frame.
- At frame end, picks the band with the most target pixels and applies a detection threshold and a frame-count hysteresis.
- Publishes zone index, steer direction and valid flag for the drive FSM.
- Sits on the 25 MHz VGA pixel path, after target_finder.

Parameters:
- H_ACTIVE, 640, active pixels per line; must be divisible by N_ZONES.
- N_ZONES, 5, number of vertical bands; 2..16.
- CNT_W, 20, per-zone accumulator width.
- PIX_THRESH, 2000, minimum winning count for target_valid.
- HYST_FRAMES, 3, consecutive agreeing frames required to change the published result; 1..15.

Ports:
- clk  in  1  pixel clock (25 MHz VGA domain).
- reset  in  1  synchronous, active-high.
- pixel_valid  in  1  active-area strobe, one pixel per cycle while high.
- is_orange  in  1  current pixel classified as target; qualified by pixel_valid.
- vsync  in  1  VGA vertical sync, active-low; falling edge marks end of frame.
- zone_idx  out  $clog2(N_ZONES)  published winning zone.
- steer  out  2  00 none, 01 left, 10 centre, 11 right.
- target_valid  out  1  published target present.
- best_count  out  CNT_W  winning count of the last evaluated frame.
- frame_done  out  1  one-cycle pulse when a frame evaluation completes.

Behaviour:
- Reset (synchronous, any state):
  - Outputs: zone_idx=0, steer=00, target_valid=0, best_count=0, frame_done=0.
  - Internal: all accumulators 0, column/zone counters 0, hysteresis counter 0, candidate cleared, state ACCUM.
  - Reset mid-SCAN aborts the evaluation; no frame_done pulse.
- Column tracking:
  - col_in_zone counts pixel_valid cycles.
  - At H_ACTIVE/N_ZONES-1 it wraps to 0 and zone_ctr increments.
  - Both counters clear on the cycle after pixel_valid falls (end of line).
  - zone_ctr saturates at N_ZONES-1 if a line exceeds H_ACTIVE.
- Accumulation (state ACCUM):
  - When pixel_valid && is_orange, acc[zone_ctr] += 1.
  - Accumulators saturate at 2^CNT_W-1 and never wrap.
- vsync edge: registered once; falling edge detected one cycle after it occurs, then ACCUM -> SCAN.
- SCAN, N_ZONES cycles, one zone per cycle in index order:
  - Running max/argmax update only on a strictly greater count, so ties go to the lowest index.
  - Each accumulator clears to 0 after it is read.
  - pixel_valid during SCAN is ignored.
- DECIDE, 1 cycle:
  - Candidate = (max >= PIX_THRESH) ? {1, argmax} : {0, 0}.
  - best_count <= max.
  - Hysteresis:
    - Candidate equals the published {target_valid, zone_idx}: counter clears.
    - Candidate equals the previous frame's candidate: counter increments; else counter = 1.
    - Counter reaching HYST_FRAMES: publish the candidate, counter clears.
  - frame_done pulses; state returns to ACCUM.
- Latency: frame_done asserts N_ZONES+2 cycles after the vsync falling edge; outputs update on the same cycle.
- steer mapping (registered with zone_idx):
  - target_valid=0 -> 00.
  - Odd N_ZONES: zone (N_ZONES-1)/2 -> 10; lower zones -> 01; higher zones -> 11.
  - Even N_ZONES: zone < N_ZONES/2 -> 01, else 11; no centre.
- A vsync falling edge while in SCAN/DECIDE is ignored; it is not queued.

Optional Feature:
- TRACKER_HYST_EN defined: hysteresis as above.
- Undefined: the hysteresis counter is not built, HYST_FRAMES is ignored, and the candidate is published directly in DECIDE every frame.

Test Plan:
Bench parameters: H_ACTIVE=20, N_ZONES=5, PIX_THRESH=10, HYST_FRAMES=3, CNT_W=8; 4 lines per frame.
- Reset check: reset asserted mid-SCAN -> all outputs 0 next cycle, no frame_done; the following frame evaluates cleanly.
- Single zone, hysteresis: orange only in columns 12..15 on all lines (zone 3, count 16), 3 frames -> frames 1-2 keep target_valid=0 while best_count=16; frame 3 gives zone_idx=3, steer=11, target_valid=1; frame_done 7 cycles after each vsync fall.
- Tie: zone 1 and zone 4 both count 12 for 3 frames -> zone_idx=1, steer=01.
- Threshold: zone 2 count 9 -> target_valid stays 0, best_count=9. Count 10 for 3 frames -> zone_idx=2, steer=10.
- Flicker rejection: after lock on zone 3, frames alternate zone 0 / zone 3 -> output stays zone 3. Then 3 consecutive zone-0 frames -> switch to zone 0.
- Saturation: all pixels orange in zone 0 across 20 lines (80 hits, CNT_W=6) -> best_count=63, no wrap. With TRACKER_HYST_EN undefined -> publishes on the first frame.
